// File: rtl/gpio_uart_tx.sv
// GPIO-to-UART bridge: rising edges of the GPIO strobe collect bits LSB-first into
// bytes, a small FIFO buffers them, and an 8N1 serialiser drives tx. Define
// GPIO_UART_PARITY_EN to add an even-parity bit after the data bits.
module gpio_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          gpio_bit,
    input  logic                          gpio_valid,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef GPIO_UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    logic          v_q;
    logic [6:0]    asm_q;
    logic [2:0]    cnt_q;
    logic          capture, push, push_ok, pop, full;
    logic [7:0]    push_byte;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          ovf_q;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sr_q, sr_d;
    logic          baud_done;
`ifdef GPIO_UART_PARITY_EN
    logic          par_q, par_d;
`endif

    // One capture per rising edge of the strobe, however long it is held.
    assign capture   = gpio_valid & ~v_q;
    assign push      = capture && (cnt_q == 3'd7);
    assign push_byte = {gpio_bit, asm_q};
    assign full      = (level_q == LW'(FIFO_DEPTH));
    assign push_ok   = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= 1'b0;
            asm_q <= '0;
            cnt_q <= '0;
        end else begin
            v_q <= gpio_valid;
            if (capture) begin
                if (cnt_q != 3'd7) asm_q[cnt_q] <= gpio_bit;
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    // NOTE: the byte storage has no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(push_ok) - LW'(pop);
            if (push && !push_ok) ovf_q <= 1'b1;
        end
    end

    assign baud_done = (baud_q == BW'(CLKS_PER_BIT - 1));

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        pop     = 1'b0;
        tx      = 1'b1;
`ifdef GPIO_UART_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != IDLE) baud_d = baud_done ? '0 : baud_q + BW'(1);

        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = START;
                    baud_d  = '0;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_done) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                tx = sr_q[0];
                if (baud_done) begin
                    sr_d  = {1'b0, sr_q[7:1]};
                    bit_d = bit_q + 3'd1;
`ifdef GPIO_UART_PARITY_EN
                    if (bit_q == 3'd7) state_d = PARITY;
`else
                    if (bit_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef GPIO_UART_PARITY_EN
            PARITY: begin
                tx = par_q;
                if (baud_done) state_d = STOP;
            end
`endif
            STOP: begin
                if (baud_done) begin
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            sr_d = mem[rd_ptr_q];
`ifdef GPIO_UART_PARITY_EN
            par_d = ^mem[rd_ptr_q];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
`ifdef GPIO_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            // NOTE: registers take non-blocking assignments so all state updates together.
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
`ifdef GPIO_UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx_busy    = (state_q != IDLE) || (level_q != '0);
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Scoreboarded bench for gpio_uart_tx: stimulus queues expected bytes, a UART
// monitor decodes tx and compares. A second, slow-baud instance exercises overflow.
module tb_gpio_uart_tx;

    localparam int CPB   = 4;
    localparam int CPB_B = 64;
`ifdef GPIO_UART_PARITY_EN
    localparam int FRAME = 11 * CPB;
`else
    localparam int FRAME = 10 * CPB;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_a = 1'b0, valid_a = 1'b0;
    logic       bit_b = 1'b0, valid_b = 1'b0;
    logic       tx_a, busy_a, ovf_a;
    logic       tx_b, busy_b, ovf_b;
    logic [3:0] level_a, level_b;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         frames = 0;
    bit         mon_en = 1'b1;
    logic [7:0] exp_q[$];
    int         starts[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gpio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .gpio_bit(bit_a), .gpio_valid(valid_a),
        .tx(tx_a), .tx_busy(busy_a), .fifo_level(level_a), .overflow(ovf_a));

    gpio_uart_tx #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .gpio_bit(bit_b), .gpio_valid(valid_b),
        .tx(tx_b), .tx_busy(busy_b), .fifo_level(level_b), .overflow(ovf_b));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic strobe(input bit sel, input logic b, input int hold);
        @(negedge clk);
        if (sel) begin bit_b = b; valid_b = 1'b1; end
        else     begin bit_a = b; valid_a = 1'b1; end
        repeat (hold) @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] d, input int hold, input bit expect_frame);
        if (expect_frame) exp_q.push_back(d);
        for (int i = 0; i < 8; i++) strobe(sel, d[i], hold);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy_a || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check({"drain_", name}, 32'(n < 3000), 32'd1);
    endtask

    // UART monitor: samples each bit one cycle after its start, pops the scoreboard.
    initial begin : monitor
        logic [7:0] got, e;
        forever begin
            @(negedge tx_a);
            if (!mon_en) continue;
            @(negedge clk);
            starts.push_back(cyc);
            @(negedge clk);
            check("start_bit", 32'(tx_a), 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                got[i] = tx_a;
            end
            if (exp_q.size() == 0) begin
                check("frame_unexpected", 32'd1, 32'd0);
                e = got;
            end else begin
                e = exp_q.pop_front();
                check("frame_data", 32'(got), 32'(e));
            end
`ifdef GPIO_UART_PARITY_EN
            repeat (CPB) @(negedge clk);
            check("parity_bit", 32'(tx_a), 32'(^e));
`endif
            repeat (CPB) @(negedge clk);
            check("stop_bit", 32'(tx_a), 32'd1);
            frames++;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k1, n, idx, f0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_a), 32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_level", 32'(level_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_tx", 32'(tx_a), 32'd1);

        // 0xA5 with single-cycle strobes, timed to the cycle
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 7; i++) strobe(1'b0, 1'(8'hA5 >> i), 1);
        @(negedge clk);
        bit_a = 1'b1; valid_a = 1'b1;
        @(negedge clk);
        check("a5_level_on_push", 32'(level_a), 32'd1);
        check("a5_tx_idle_on_push", 32'(tx_a), 32'd1);
        check("a5_busy_on_push", 32'(busy_a), 32'd1);
        valid_a = 1'b0;
        @(negedge clk);
        k1 = cyc;
        check("a5_tx_start_low", 32'(tx_a), 32'd0);
        check("a5_level_after_pop", 32'(level_a), 32'd0);
        n = 0;
        while (busy_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("a5_busy_fall_cycles", 32'(cyc - k1), 32'(FRAME));
        wait_idle("a5");

        // Held strobes: 5 cycles each still give one bit per write
        f0 = frames;
        exp_q.push_back(8'h3C);
        for (int i = 0; i < 7; i++) strobe(1'b0, 1'(8'h3C >> i), 5);
        repeat (3) @(negedge clk);
        check("held_level_after7", 32'(level_a), 32'd0);
        check("held_busy_after7", 32'(busy_a), 32'd0);
        strobe(1'b0, 1'b0, 5);
        wait_idle("held");
        check("held_one_frame", 32'(frames - f0), 32'd1);

        // Three bytes back-to-back
        idx = starts.size();
        send_byte(1'b0, 8'h01, 1, 1'b1);
        check("b2b_level_1", 32'(level_a), 32'd1);
        send_byte(1'b0, 8'h02, 1, 1'b1);
        check("b2b_level_still_1", 32'(level_a), 32'd1);
        send_byte(1'b0, 8'h03, 1, 1'b1);
        check("b2b_level_2", 32'(level_a), 32'd2);
        wait_idle("b2b");
        check("b2b_level_0", 32'(level_a), 32'd0);
        check("b2b_frames", 32'(starts.size() - idx), 32'd3);
        if (starts.size() >= idx + 3) begin
            check("b2b_gap_1_2", 32'(starts[idx + 1] - starts[idx]), 32'(FRAME));
            check("b2b_gap_2_3", 32'(starts[idx + 2] - starts[idx + 1]), 32'(FRAME));
        end

        // Parity test byte (plain frame when parity is disabled)
        send_byte(1'b0, 8'h07, 1, 1'b1);
        wait_idle("x07");

        // Overflow on the slow instance: 1 in flight, 8 buffered, 10th dropped
        for (int b = 0; b < 9; b++) send_byte(1'b1, 8'(8'h10 + b), 1, 1'b0);
        check("ovf_level_full", 32'(level_b), 32'd8);
        check("ovf_not_yet", 32'(ovf_b), 32'd0);
        send_byte(1'b1, 8'h19, 1, 1'b0);
        @(negedge clk);
        check("ovf_level_after_drop", 32'(level_b), 32'd8);
        check("ovf_set", 32'(ovf_b), 32'd1);
        n = 0;
        while (level_b != 4'd7 && n < 1500) begin
            @(negedge clk);
            n++;
        end
        check("ovf_pop_after_frame", 32'(level_b), 32'd7);
        check("ovf_sticky", 32'(ovf_b), 32'd1);

        // Reset in the middle of DATA bit 3, with a partial byte pending
        mon_en = 1'b0;
        send_byte(1'b0, 8'h52, 1, 1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b0, 1'b1, 1);
        repeat (10) @(negedge clk);
        check("mid_tx_bit3", 32'(tx_a), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_tx_async", 32'(tx_a), 32'd1);
        check("mid_rst_level", 32'(level_a), 32'd0);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_ovf_b", 32'(ovf_b), 32'd0);
        check("mid_rst_level_b", 32'(level_b), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        send_byte(1'b0, 8'hC3, 1, 1'b1);
        wait_idle("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
